// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment display path.
package display_pkg;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        SHOW1,
        SHOW2,
        GAP
    } disp_state_t;

    // Default timing: one second per digit, 200 ms blank at 50 MHz.
    localparam int T_DIGIT_DEF = 50_000_000;
    localparam int T_GAP_DEF   = 10_000_000;

    // Display driver phases, shared so driver and scheduler agree on sequencing.
    typedef enum logic [1:0] {
        PH_OFF,
        PH_DIGIT0,
        PH_DIGIT1,
        PH_BLANK
    } drv_phase_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 any
);

    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt_wide;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        rot_req  = N'({req, req} >> ptr);
        rot_gnt  = rot_req & (~rot_req + 1'b1);
        gnt_wide = {{N{1'b0}}, rot_gnt} << ptr;
        gnt      = gnt_wide[N-1:0] | gnt_wide[2*N-1:N];
        any      = |req;
    end

endmodule

// File: rtl/display_scheduler.sv
// Sequencer and round-robin arbiter feeding the two-digit display driver.
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int T_DIGIT = T_DIGIT_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*16-1:0] valor,
    input  logic                cancel,
    output logic [N_REQ-1:0]    ack,
    output logic                disp_iniciar,
    output logic                pulso_mitad,
    output logic                pulso_fin,
    output logic [15:0]         disp_valor,
    output logic                busy
);

    localparam int T_MAX = (T_DIGIT > T_GAP) ? T_DIGIT : T_GAP;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int PTR_W = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(T_DIGIT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(T_GAP - 1);

    disp_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             any_req;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .any (any_req)
    );

    // Encode the one-hot grant into a client index.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    // Next state and counter; a cancel collapses the show phase onto its final cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) state_n = START;
            end
            START: begin
                state_n = SHOW1;
                cnt_n   = DIGIT_LOAD;
            end
            SHOW1: begin
                if (cancel) begin
                    state_n = SHOW2;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = SHOW2;
                    cnt_n   = DIGIT_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SHOW2: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                end else if (cancel) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointer, latched value and strobes.
    // Strobes mark the cycle a phase reaches zero; they are decoded from the
    // next state so each one comes straight out of a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            win_idx      <= '0;
            ack          <= '0;
            disp_iniciar <= 1'b0;
            pulso_mitad  <= 1'b0;
            pulso_fin    <= 1'b0;
            disp_valor   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && any_req) begin
                win_idx    <= gnt_idx;
                disp_valor <= valor[gnt_idx*16 +: 16];
            end
            if (state == START) begin
                rr_ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            ack          <= (state_n == START) ? gnt : '0;
            disp_iniciar <= (state_n == START);
            pulso_mitad  <= (state_n == SHOW1) && (cnt_n == '0);
            pulso_fin    <= (state_n == SHOW2) && (cnt_n == '0);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (N_REQ=3, T_DIGIT=4, T_GAP=2).
module tb_display_scheduler;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int TG = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*16-1:0] valor;
    logic            cancel;
    logic [N-1:0]    ack;
    logic            disp_iniciar;
    logic            pulso_mitad;
    logic            pulso_fin;
    logic [15:0]     disp_valor;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    display_scheduler #(.N_REQ(N), .T_DIGIT(TD), .T_GAP(TG)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .valor        (valor),
        .cancel       (cancel),
        .ack          (ack),
        .disp_iniciar (disp_iniciar),
        .pulso_mitad  (pulso_mitad),
        .pulso_fin    (pulso_fin),
        .disp_valor   (disp_valor),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        cancel  = 1'b0;
        valor   = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Requests during reset are ignored; outputs stay zero after release with no req.
    task automatic test_reset();
        reset_n = 1'b0;
        cancel  = 1'b0;
        for (int d = 0; d < 6; d++) begin
            @(posedge clk); #1;
            if (d == 3) reset_n = 1'b1;
            req   = (d < 3) ? 3'b111 : 3'b000;
            valor = {16'($urandom), 16'($urandom), 16'($urandom)};
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy, disp_valor} !== 23'd0)
                $display("FAIL reset d=%0d got=%h exp=0", d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy, disp_valor});
        end
    endtask

    task automatic test_single();
        logic [N-1:0] e_ack;
        logic         e_ini, e_mit, e_fin, e_busy;
        logic [15:0]  e_val;
        do_reset();
        for (int d = 0; d <= 14; d++) begin
            @(posedge clk); #1;
            req   = (d <= 1) ? 3'b010 : 3'b000;
            valor = {16'($urandom), (d == 0) ? 16'h003A : 16'($urandom), 16'($urandom)};
            e_ini  = (d == 1);
            e_ack  = (d == 1) ? 3'b010 : 3'b000;
            e_mit  = (d == 1 + TD);
            e_fin  = (d == 1 + 2*TD);
            e_busy = (d >= 1) && (d <= 2*TD + TG + 1);
            e_val  = (d >= 1) ? 16'h003A : 16'h0000;
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL single_ctrl d=%0d got=%b exp=%b", d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
            checks++;
            if (disp_valor !== e_val) begin
                failures++;
                $display("FAIL single_valor d=%0d got=%h exp=%h", d, disp_valor, e_val);
            end
        end
    endtask

    // All clients held: grants rotate 0,1,2,0 with 12-cycle spacing.
    task automatic test_round_robin();
        logic [N-1:0] e_ack;
        logic         e_ini, e_mit, e_fin, e_busy;
        logic [15:0]  e_val;
        int           ph, msg;
        do_reset();
        for (int d = 0; d <= 40; d++) begin
            @(posedge clk); #1;
            req   = 3'b111;
            valor = {16'hC002, 16'hC001, 16'hC000};
            ph    = (d - 1) % 12;
            msg   = ((d - 1) / 12) % 3;
            e_ini  = (d >= 1) && (ph == 0);
            e_ack  = e_ini ? 3'(1 << msg) : 3'b000;
            e_mit  = (d >= 1) && (ph == TD);
            e_fin  = (d >= 1) && (ph == 2*TD);
            e_busy = (d >= 1) && (ph != 11);
            e_val  = (d >= 1) ? 16'hC000 + 16'(msg) : 16'h0000;
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL rr_ctrl d=%0d got=%b exp=%b", d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
            checks++;
            if (disp_valor !== e_val) begin
                failures++;
                $display("FAIL rr_valor d=%0d got=%h exp=%h", d, disp_valor, e_val);
            end
        end
    endtask

    // Single-cycle cancel in cycle k (message starts in cycle 1).
    task automatic test_cancel(input int k);
        logic [N-1:0] e_ack;
        logic         e_ini, e_mit, e_fin, e_busy;
        int           fin_d;
        do_reset();
        fin_d = (k >= 2 && k < 1 + 2*TD) ? k + 1 : 1 + 2*TD;
        for (int d = 0; d <= 14; d++) begin
            @(posedge clk); #1;
            req    = (d <= 1) ? 3'b001 : 3'b000;
            valor  = {16'h0, 16'h0, 16'h0C0C};
            cancel = (d == k);
            e_ini  = (d == 1);
            e_ack  = (d == 1) ? 3'b001 : 3'b000;
            e_mit  = (d == 1 + TD) && (fin_d > 1 + TD);
            e_fin  = (d == fin_d);
            e_busy = (d >= 1) && (d < fin_d + TG + 1);
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL cancel_k%0d d=%0d got=%b exp=%b", k, d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
        end
        cancel = 1'b0;
    endtask

    // Cancel raised on the natural end cycle and held through GAP and IDLE.
    task automatic test_cancel_at_end();
        logic [N-1:0] e_ack;
        logic         e_ini, e_mit, e_fin, e_busy;
        int           fins;
        do_reset();
        fins = 0;
        for (int d = 0; d <= 16; d++) begin
            @(posedge clk); #1;
            req    = (d <= 1) ? 3'b100 : 3'b000;
            valor  = {16'h5A5A, 16'h0, 16'h0};
            cancel = (d >= 1 + 2*TD);
            e_ini  = (d == 1);
            e_ack  = (d == 1) ? 3'b100 : 3'b000;
            e_mit  = (d == 1 + TD);
            e_fin  = (d == 1 + 2*TD);
            e_busy = (d >= 1) && (d <= 2*TD + TG + 1);
            @(negedge clk);
            if (pulso_fin === 1'b1) fins++;
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL cancel_end d=%0d got=%b exp=%b", d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
        end
        checks++;
        if (fins != 1) begin
            failures++;
            $display("FAIL cancel_end_count got=%0d exp=1", fins);
        end
        cancel = 1'b0;
    endtask

    // Asynchronous reset mid-SHOW2 clears outputs at once and returns the pointer to 0.
    task automatic test_reset_mid();
        logic [N-1:0] e_ack;
        logic         e_ini, e_mit, e_fin, e_busy;
        logic [15:0]  e_val;
        do_reset();
        for (int d = 0; d <= 23; d++) begin
            @(posedge clk); #1;
            if (d <= 1)       req = 3'b010;
            else if (d < 10)  req = 3'b000;
            else if (d <= 11) req = 3'b101;
            else              req = 3'b100;
            if (d == 10) reset_n = 1'b1;
            valor = (d < 10) ? {16'h0, 16'hBEEF, 16'h0} : {16'h2222, 16'h0000, 16'h1111};
            if (d == 7) begin
                #2 reset_n = 1'b0;
                #1;
                checks++;
                if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy, disp_valor} !== 23'd0) begin
                    failures++;
                    $display("FAIL reset_async got=%h exp=0",
                             {ack, disp_iniciar, pulso_mitad, pulso_fin, busy, disp_valor});
                end
            end
            e_ini  = (d == 1) || (d == 11) || (d == 23);
            e_ack  = (d == 1) ? 3'b010 : (d == 11) ? 3'b001 : (d == 23) ? 3'b100 : 3'b000;
            e_mit  = (d == 1 + TD) || (d == 11 + TD);
            e_fin  = (d == 11 + 2*TD);
            e_busy = (d >= 1 && d <= 6) || (d >= 11 && d <= 11 + 2*TD + TG) || (d >= 23);
            e_val  = (d >= 23) ? 16'h2222 : (d >= 11) ? 16'h1111 :
                     (d >= 1 && d <= 6) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL reset_mid_ctrl d=%0d got=%b exp=%b", d,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
            checks++;
            if (disp_valor !== e_val) begin
                failures++;
                $display("FAIL reset_mid_valor d=%0d got=%h exp=%h", d, disp_valor, e_val);
            end
        end
    endtask

    // Random traffic against a timeline model: each message is described by its
    // start cycle c0 and its end-strobe cycle; everything else follows from those.
    task automatic test_random(input int ncyc);
        bit           started, idle, found;
        int           c0, fin_c, win, ptr, idx;
        logic [15:0]  mval;
        logic [N-1:0] r, e_ack;
        logic         can, rn, e_ini, e_mit, e_fin, e_busy;
        logic [15:0]  e_val;
        logic [47:0]  v;
        started = 0; c0 = 0; fin_c = 0; win = 0; ptr = 0; mval = '0; idle = 1;
        do_reset();
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk); #1;
            r   = 3'($urandom & $urandom);
            can = ($urandom_range(0, 7) == 0);
            rn  = ($urandom_range(0, 99) != 0);
            v   = {16'($urandom), 16'($urandom), 16'($urandom)};
            req = r; cancel = can; valor = v; reset_n = rn;
            if (!rn) begin
                started = 0; ptr = 0; mval = '0;
                e_ack = '0; e_ini = 0; e_mit = 0; e_fin = 0; e_busy = 0; e_val = '0;
                idle = 1;
            end else begin
                idle   = !started || (n >= fin_c + TG + 1);
                e_busy = !idle;
                e_ini  = started && (n == c0);
                e_ack  = e_ini ? 3'(1 << win) : 3'b000;
                e_mit  = started && (n == c0 + TD) && (fin_c > c0 + TD);
                e_fin  = started && (n == fin_c);
                e_val  = mval;
            end
            @(negedge clk);
            checks++;
            if ({ack, disp_iniciar, pulso_mitad, pulso_fin, busy} !== {e_ack, e_ini, e_mit, e_fin, e_busy}) begin
                failures++;
                $display("FAIL random_ctrl n=%0d got=%b exp=%b", n,
                         {ack, disp_iniciar, pulso_mitad, pulso_fin, busy}, {e_ack, e_ini, e_mit, e_fin, e_busy});
            end
            checks++;
            if (disp_valor !== e_val) begin
                failures++;
                $display("FAIL random_valor n=%0d got=%h exp=%h", n, disp_valor, e_val);
            end
            if (rn) begin
                if (idle && (r != '0)) begin
                    found = 0;
                    for (int i = 0; i < N; i++) begin
                        idx = (ptr + i) % N;
                        if (!found && r[idx]) begin
                            found = 1;
                            win   = idx;
                        end
                    end
                    started = 1;
                    c0      = n + 1;
                    fin_c   = c0 + 2*TD;
                    mval    = v[win*16 +: 16];
                    ptr     = (win + 1) % N;
                end else if (started && can && n >= c0 + 1 && n < fin_c) begin
                    fin_c = n + 1;
                end
            end
        end
        reset_n = 1'b1;
        req     = '0;
        cancel  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        valor   = '0;
        cancel  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_cancel(3);
        test_cancel(4);
        test_cancel(5);
        test_cancel_at_end();
        test_reset_mid();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
